key_schedule_ctrl: RTL and testbench
====================================

Name: key_schedule_ctrl

Overview:
- Iterative, sequenced replacement for the unrolled key expansion: produces one expanded key word per clock using a single 4-byte SubWord S-box instance.
- Stores all 4*(NR+1) words in an internal round-key store.
- Serves per-round 128-bit key reads to the cipher/inverse-cipher datapath, in any order (decryption reads round NR down to 0).
- Sits between the key source (SHA-256 derived key) and the AES round datapath.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8 supported).
- NR, 10, number of rounds (10/12/14, must pair with NK).
- RW, 4, width of round index port.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active high.
- start  in  1  single-cycle request to expand key.
- key  in  NK*32  cipher key; word 0 in the most significant 32 bits; sampled only on the start cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when expansion completes.
- key_ready  out  1  level; round-key store valid for the current key.
- rk_rd_en  in  1  round-key read request.
- rk_rd_round  in  RW  round index 0..NR.
- rk_rd_data  out  128  words 4r..4r+3, word 4r in the most significant bits.
- rk_rd_valid  out  1  read data valid, one cycle after rk_rd_en.
- rk_rd_err  out  1  with rk_rd_valid: request rejected.

Behaviour:
- Reset values: busy=0, done=0, key_ready=0, rk_rd_valid=0, rk_rd_err=0, rk_rd_data=0; FSM=IDLE; word counter=0; rcon=0x01.
- FSM states: IDLE, LOAD, EXPAND, READY.
- start accepted in IDLE or READY; ignored in LOAD/EXPAND.
- On acceptance: key is latched and key_ready clears on the next edge.
- LOAD (1 cycle): writes w[0..NK-1] from the latched key; word counter i=NK; busy=1.
- EXPAND (4*(NR+1)-NK cycles), one word per cycle:
  - temp = w[i-1].
  - If i%NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon = xtime(rcon), i.e. shift left, XOR 0x1B if bit7 was set.
  - Else if NK>6 and i%NK==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp; i++.
- Exit from EXPAND: after writing w[4*(NR+1)-1], go to READY.
  - done pulses for exactly 1 cycle on READY entry; busy falls the same edge; key_ready=1.
- Latency, defaults: start sampled at edge T; LOAD at T+1; EXPAND T+2..T+41; done=1 and key_ready=1 at T+42.
- Restart in READY: start re-latches the key, drops key_ready, repeats the full sequence; rcon resets to 0x01 on LOAD.
- Reads: rk_rd_en sampled every cycle; response appears on the next cycle.
  - If key_ready=1 and rk_rd_round<=NR: rk_rd_data = store words, rk_rd_valid=1, rk_rd_err=0.
  - If key_ready=0 or round>NR: rk_rd_valid=1, rk_rd_err=1, rk_rd_data=0.
  - Without rk_rd_en: rk_rd_valid=0 and rk_rd_data holds its last value.
- Simultaneous start and rk_rd_en in READY: the read is served from the old key (store not yet overwritten); expansion proceeds normally.
- rst asserted mid-EXPAND: next edge returns to IDLE with all outputs at reset values; partial store contents are not readable because key_ready=0.
- S-box: single combinational 4-byte lookup, FIPS-197 table; no multi-cycle S-box.

Test Plan:
- rst, then start with key=2b7e151628aed2a6abf7158809cf4f3c (NK=4,NR=10) at T.
  -> busy T+1..T+41, done pulse only at T+42, key_ready=1.
  -> read round 1 = a0fafe1788542cb123a339392a6c7605.
  -> read round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Decryption order: reads rounds 10,9,...,0 back-to-back, one per cycle -> rk_rd_valid every cycle, round 0 equals the key, no err.
- Read round 11, and any read before the first done -> rk_rd_valid=1, rk_rd_err=1, data=0.
- start pulses at T+5 and T+20 during EXPAND -> ignored; done still at T+42; outputs unchanged vs scenario 1.
- rst at T+10, then start at T+15 with key 000102030405060708090a0b0c0d0e0f -> done at T+57; round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- NK=8,NR=14, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  -> w[8]=9ba35411, w[59]=706c631e.
  -> done 1+1+52 = 54 edges after start.

Source files
------------

// File: rtl/key_schedule_ctrl_if.sv
// Start/status handshake and round-key read bus shared by the key schedule
// controller (slave) and the key source / cipher datapath (master).
interface key_schedule_ctrl_if #(
    parameter int NK = 4,
    parameter int RW = 4
);
    logic              start;
    logic [NK*32-1:0]  key;
    logic              busy;
    logic              done;
    logic              key_ready;
    logic              rk_rd_en;
    logic [RW-1:0]     rk_rd_round;
    logic [127:0]      rk_rd_data;
    logic              rk_rd_valid;
    logic              rk_rd_err;

    modport master (
        output start, key, rk_rd_en, rk_rd_round,
        input  busy, done, key_ready, rk_rd_data, rk_rd_valid, rk_rd_err
    );

    modport slave (
        input  start, key, rk_rd_en, rk_rd_round,
        output busy, done, key_ready, rk_rd_data, rk_rd_valid, rk_rd_err
    );
endinterface

// File: rtl/key_schedule_ctrl.sv
// Sequential AES key expansion: one expanded word per clock through a single
// SubWord lookup, with a round-key store serving 128-bit reads in any order.
module key_schedule_ctrl #(
    parameter int NK = 4,
    parameter int NR = 10,
    parameter int RW = 4
) (
    input logic                clk,
    input logic                rst,
    key_schedule_ctrl_if.slave bus
);
    localparam int TOTAL = 4 * (NR + 1);
    localparam int IW    = $clog2(TOTAL);

    // FIPS-197 forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [2:0]        mod_q, mod_d;
    logic [7:0]        rcon_q, rcon_d;
    logic [NK*32-1:0]  key_q, key_d;
    logic [31:0]       store_q [TOTAL];
    logic [31:0]       store_d [TOTAL];
    logic              done_q, done_d;
    logic [127:0]      rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;

    logic [31:0]       prev_word, back_word, sub_in, sub_out, temp;
    logic [IW-1:0]     rd_base;
    logic              last_word, key_ready, rd_ok;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = SBOX[2047 - 8*int'(w[8*b +: 8]) -: 8];
        end
        return r;
    endfunction

    assign last_word = (i_q == IW'(TOTAL - 1));
    assign key_ready = (state_q == READY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, READY: if (bus.start) state_d = LOAD;
            LOAD:        state_d = EXPAND;
            EXPAND:      if (last_word) state_d = READY;
            default:     state_d = IDLE;
        endcase
    end

    // mod_q tracks i % NK so no divider is needed; the one S-box sees RotWord only on i%NK==0.
    always_comb begin
        prev_word = store_q[i_q - IW'(1)];
        back_word = store_q[i_q - IW'(NK)];
        sub_in    = (mod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_out   = sub_word(sub_in);
        temp      = prev_word;
        if (mod_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (NK > 6 && mod_q == 3'd4) begin
            temp = sub_out;
        end
    end

    always_comb begin
        key_d   = key_q;
        i_d     = i_q;
        mod_d   = mod_q;
        rcon_d  = rcon_q;
        store_d = store_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, READY: if (bus.start) key_d = bus.key;
            LOAD: begin
                for (int j = 0; j < NK; j++) begin
                    store_d[j] = key_q[NK*32-1-32*j -: 32];
                end
                i_d    = IW'(NK);
                mod_d  = 3'd0;
                rcon_d = 8'h01;
            end
            EXPAND: begin
                store_d[i_q] = back_word ^ temp;
                i_d          = i_q + IW'(1);
                mod_d        = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
                if (mod_q == 3'd0) begin
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
                done_d = last_word;
            end
            default: ;
        endcase
    end

    // Reads see the store as of this edge, so a read alongside a restart returns the old key.
    always_comb begin
        rd_ok      = key_ready && (bus.rk_rd_round <= RW'(NR));
        rd_base    = rd_ok ? IW'({bus.rk_rd_round, 2'b00}) : '0;
        rd_valid_d = bus.rk_rd_en;
        rd_err_d   = 1'b0;
        rd_data_d  = rd_data_q;
        if (bus.rk_rd_en) begin
            if (rd_ok) begin
                rd_data_d = {store_q[rd_base], store_q[rd_base + IW'(1)],
                             store_q[rd_base + IW'(2)], store_q[rd_base + IW'(3)]};
            end else begin
                rd_err_d  = 1'b1;
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        store_q <= store_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q      <= '0;
            i_q        <= '0;
            mod_q      <= '0;
            rcon_q     <= 8'h01;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            key_q      <= key_d;
            i_q        <= i_d;
            mod_q      <= mod_d;
            rcon_q     <= rcon_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    always_comb begin
        bus.busy        = (state_q == LOAD) || (state_q == EXPAND);
        bus.done        = done_q;
        bus.key_ready   = key_ready;
        bus.rk_rd_data  = rd_data_q;
        bus.rk_rd_valid = rd_valid_q;
        bus.rk_rd_err   = rd_err_q;
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Randomized bench for key_schedule_ctrl (AES-128 and AES-256 instances) checked
// against a reference key expansion whose S-box is derived from GF(2^8) inverses.
module tb_key_schedule_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   failCount = 0;
    logic [7:0] refSbox [256];

    always #5 clk = ~clk;

    key_schedule_ctrl_if #(.NK(4), .RW(4)) bus4 ();
    key_schedule_ctrl_if #(.NK(8), .RW(4)) bus8 ();

    key_schedule_ctrl #(.NK(4), .NR(10), .RW(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    key_schedule_ctrl #(.NK(8), .NR(14), .RW(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box built from its definition: multiplicative inverse followed by the affine map.
    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gfMul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            end
            refSbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] refSubWord(input logic [31:0] w);
        return {refSbox[w[31:24]], refSbox[w[23:16]], refSbox[w[15:8]], refSbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] refRound(input logic [255:0] k, input int nk, input int nr, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = refSubWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gfMul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = refSubWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic int nkOf(input int which);
        return (which == 4) ? 4 : 8;
    endfunction

    function automatic int nrOf(input int which);
        return (which == 4) ? 10 : 14;
    endfunction

    function automatic int latOf(input int which);
        return 4 * (nrOf(which) + 1) - nkOf(which) + 2;
    endfunction

    function automatic logic [255:0] randKey(input int nk);
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        if (nk == 4) r[127:0] = '0;
        return r;
    endfunction

    function automatic logic [2:0] ctrlOf(input int which);
        return (which == 4) ? {bus4.busy, bus4.done, bus4.key_ready}
                            : {bus8.busy, bus8.done, bus8.key_ready};
    endfunction

    function automatic logic [129:0] readOf(input int which);
        return (which == 4) ? {bus4.rk_rd_valid, bus4.rk_rd_err, bus4.rk_rd_data}
                            : {bus8.rk_rd_valid, bus8.rk_rd_err, bus8.rk_rd_data};
    endfunction

    task automatic applyStimulus(input int which, input logic s, input logic [255:0] k);
        if (which == 4) begin
            bus4.start = s;
            bus4.key   = k[255:128];
        end else begin
            bus8.start = s;
            bus8.key   = k;
        end
    endtask

    task automatic driveRead(input int which, input logic en, input int round);
        if (which == 4) begin
            bus4.rk_rd_en    = en;
            bus4.rk_rd_round = 4'(round);
        end else begin
            bus8.rk_rd_en    = en;
            bus8.rk_rd_round = 4'(round);
        end
    endtask

    task automatic checkRead(input int which, input int round, input logic [255:0] k,
                             input logic ready, input string tag);
        logic [129:0] rsp;
        logic         expErr;
        logic [127:0] expData;
        driveRead(which, 1'b1, round);
        @(negedge clk);
        rsp = readOf(which);
        driveRead(which, 1'b0, 0);
        expErr  = !ready || (round > nrOf(which));
        expData = expErr ? '0 : refRound(k, nkOf(which), nrOf(which), round);
        checkOutput({tag, " flags"}, 128'(rsp[129:128]), 128'({1'b1, expErr}));
        checkOutput({tag, " data"}, rsp[127:0], expData);
    endtask

    // Starts an expansion at the next edge T and checks busy/done/key_ready at every
    // cycle through T+lat+1; glitch starts at g1/g2 must be ignored.
    task automatic runStart(input int which, input logic [255:0] k, input int g1, input int g2,
                            input int rdRound, input logic [255:0] oldKey, input string tag);
        int lat;
        logic [2:0] c;
        logic [129:0] rsp;
        logic expErr;
        lat = latOf(which);
        applyStimulus(which, 1'b1, k);
        if (rdRound >= 0) driveRead(which, 1'b1, rdRound);
        for (int lbl = 1; lbl <= lat + 1; lbl++) begin
            @(negedge clk);
            c = ctrlOf(which);
            if (lbl == 1 && rdRound >= 0) begin
                rsp    = readOf(which);
                expErr = rdRound > nrOf(which);
                driveRead(which, 1'b0, 0);
                checkOutput({tag, " overlap flags"}, 128'(rsp[129:128]), 128'({1'b1, expErr}));
                checkOutput({tag, " overlap data"}, rsp[127:0],
                            expErr ? 128'h0 : refRound(oldKey, nkOf(which), nrOf(which), rdRound));
            end
            applyStimulus(which, (lbl == g1) || (lbl == g2),
                          (lbl == g1) || (lbl == g2) ? randKey(nkOf(which)) : k);
            checkOutput($sformatf("%s busy T+%0d", tag, lbl), 128'(c[2]), 128'(lbl < lat));
            checkOutput($sformatf("%s done T+%0d", tag, lbl), 128'(c[1]), 128'(lbl == lat));
            checkOutput($sformatf("%s key_ready T+%0d", tag, lbl), 128'(c[0]), 128'(lbl >= lat));
        end
        applyStimulus(which, 1'b0, k);
    endtask

    initial begin
        logic [255:0] key1, keyZ, key8, curKey, newKey;
        logic [129:0] rsp;
        int g1, g2, rd, lat;

        buildSbox();
        rst = 1'b1;
        applyStimulus(4, 1'b0, '0);
        applyStimulus(8, 1'b0, '0);
        driveRead(4, 1'b0, 0);
        driveRead(8, 1'b0, 0);
        repeat (3) @(negedge clk);
        rsp = readOf(4);
        checkOutput("reset ctrl4", 128'({ctrlOf(4), rsp[129:128]}), 128'h0);
        checkOutput("reset data4", rsp[127:0], 128'h0);
        rsp = readOf(8);
        checkOutput("reset ctrl8", 128'({ctrlOf(8), rsp[129:128]}), 128'h0);
        checkOutput("reset data8", rsp[127:0], 128'h0);
        rst = 1'b0;
        @(negedge clk);

        checkRead(4, 0, '0, 1'b0, "pre-done read");

        key1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        runStart(4, key1, 0, 0, -1, '0, "fips128");
        driveRead(4, 1'b1, 1);
        @(negedge clk);
        rsp = readOf(4);
        checkOutput("fips128 round1", rsp[127:0], 128'ha0fafe1788542cb123a339392a6c7605);
        driveRead(4, 1'b1, 10);
        @(negedge clk);
        rsp = readOf(4);
        driveRead(4, 1'b0, 0);
        checkOutput("fips128 round10", rsp[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        driveRead(4, 1'b1, 10);
        for (int r = 10; r >= 0; r--) begin
            @(negedge clk);
            rsp = readOf(4);
            if (r > 0) driveRead(4, 1'b1, r - 1);
            else driveRead(4, 1'b0, 0);
            checkOutput($sformatf("decrypt r%0d flags", r), 128'(rsp[129:128]), 128'(2'b10));
            checkOutput($sformatf("decrypt r%0d data", r), rsp[127:0], refRound(key1, 4, 10, r));
            if (r == 0) checkOutput("decrypt round0 is key", rsp[127:0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        end
        checkRead(4, 11, key1, 1'b1, "round11");
        checkRead(4, 15, key1, 1'b1, "round15");

        newKey = randKey(4);
        runStart(4, newKey, 5, 20, 7, key1, "restart");
        curKey = newKey;
        for (int n = 0; n < 4; n++) checkRead(4, $urandom_range(0, 10), curKey, 1'b1, "restart read");

        applyStimulus(4, 1'b1, randKey(4));
        for (int lbl = 1; lbl < 15; lbl++) begin
            @(negedge clk);
            applyStimulus(4, 1'b0, '0);
            if (lbl == 10) rst = 1'b1;
            if (lbl == 11) begin
                rsp = readOf(4);
                rst = 1'b0;
                checkOutput("mid-expand reset ctrl", 128'({ctrlOf(4), rsp[129:128]}), 128'h0);
                checkOutput("mid-expand reset data", rsp[127:0], 128'h0);
                driveRead(4, 1'b1, 0);
            end
            if (lbl == 12) begin
                rsp = readOf(4);
                driveRead(4, 1'b0, 0);
                checkOutput("after reset read flags", 128'(rsp[129:128]), 128'(2'b11));
                checkOutput("after reset read data", rsp[127:0], 128'h0);
            end
        end
        keyZ = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        runStart(4, keyZ, 0, 0, -1, '0, "post-reset");
        driveRead(4, 1'b1, 10);
        @(negedge clk);
        rsp = readOf(4);
        driveRead(4, 1'b0, 0);
        checkOutput("post-reset round10", rsp[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        curKey = keyZ;

        lat = latOf(4);
        for (int it = 0; it < 4; it++) begin
            newKey = randKey(4);
            g1 = $urandom_range(1, lat - 1);
            g2 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat - 1) : 0;
            rd = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1;
            runStart(4, newKey, g1, g2, rd, curKey, $sformatf("rand4 #%0d", it));
            curKey = newKey;
            for (int n = 0; n < 4; n++) checkRead(4, $urandom_range(0, 15), curKey, 1'b1, "rand4 read");
        end

        checkRead(8, 3, '0, 1'b0, "nk8 pre-done read");
        key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        runStart(8, key8, 0, 0, -1, '0, "fips256");
        driveRead(8, 1'b1, 2);
        @(negedge clk);
        rsp = readOf(8);
        driveRead(8, 1'b1, 14);
        checkOutput("fips256 w8", 128'(rsp[127:96]), 128'h9ba35411);
        @(negedge clk);
        rsp = readOf(8);
        driveRead(8, 1'b0, 0);
        checkOutput("fips256 w59", 128'(rsp[31:0]), 128'h706c631e);
        checkRead(8, 14, key8, 1'b1, "fips256 round14");
        checkRead(8, 15, key8, 1'b1, "nk8 round15");

        lat = latOf(8);
        newKey = randKey(8);
        runStart(8, newKey, $urandom_range(1, lat - 1), $urandom_range(1, lat - 1), -1, '0, "rand8");
        for (int n = 0; n < 5; n++) checkRead(8, $urandom_range(0, 14), newKey, 1'b1, "rand8 read");

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
